unsigned_8x8_mul: RTL and testbench



---
 rtl/mul_pkg.sv | 84 ++++++++
 rtl/mul_fa.sv | 25 ++
 rtl/unsigned_8x8_mul.sv | 160 ++++++++++++++++
 tb/tb_unsigned_8x8_mul.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// ============================================================================
//  Module   : mul_pkg
//  Purpose  : Shared types, sizes and Dadda-tree shape helpers for the
//             unsigned 8x8 multiplier.
//  Contents : BIT, PW, NSTAGE, opnd_t, prod_t, dadda_height(),
//             dadda_cnt() (per-stage, per-column height / adder counts)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_pkg;

  localparam int BIT    = 8;
  localparam int PW     = 2 * BIT;
  localparam int NSTAGE = 4;

  // Selectors for dadda_cnt()
  localparam int KIND_H  = 0;  // column height entering the stage
  localparam int KIND_FA = 1;  // full adders placed in the column
  localparam int KIND_HA = 2;  // half adders placed in the column

  typedef logic [BIT-1:0] opnd_t;
  typedef logic [PW-1:0]  prod_t;

  // Target maximum column height after each reduction stage.
  function automatic int dadda_height(input int stage);
    case (stage)
      0:       return 6;
      1:       return 4;
      2:       return 3;
      default: return 2;
    endcase
  endfunction

  // Replays the Dadda reduction column by column (carries ripple into the
  // next column within the same stage) and reports one figure for the
  // requested stage/column. Stage NSTAGE reports the final two-row heights.
  function automatic int dadda_cnt(input int stage, input int col, input int kind);
    logic [4*PW-1:0] h;  // 4-bit height per column
    int carry;
    int eff;
    int nf;
    int nh;
    int d;
    int r;
    r = 0;
    for (int c = 0; c < PW; c++) begin
      if (c < BIT)           h[4*c +: 4] = 4'(c + 1);
      else if (c < PW - 1)   h[4*c +: 4] = 4'(PW - 1 - c);
      else                   h[4*c +: 4] = 4'd0;
    end
    for (int s = 0; s <= NSTAGE; s++) begin
      carry = 0;
      d     = dadda_height(s);
      for (int c = 0; c < PW; c++) begin
        eff = int'(h[4*c +: 4]) + carry;
        nf  = 0;
        nh  = 0;
        if (s < NSTAGE) begin
          while (eff > d) begin
            if (eff - d >= 2) begin
              nf  = nf + 1;
              eff = eff - 2;
            end else begin
              nh  = nh + 1;
              eff = eff - 1;
            end
          end
        end
        if (s == stage && c == col) begin
          if (kind == KIND_H)       r = int'(h[4*c +: 4]);
          else if (kind == KIND_FA) r = nf;
          else                      r = nh;
        end
        h[4*c +: 4] = 4'(eff);
        carry       = nf + nh;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_fa.sv
// ============================================================================
//  Module   : mul_fa
//  Purpose  : 1-bit full adder cell used by the Dadda reduction tree.
//  Ports    : a, b, cin (in)  -> s (sum), cout (carry)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_ab;

  assign w_ab = a ^ b;
  assign s    = w_ab ^ cin;
  assign cout = (a & b) | (cin & w_ab);

endmodule

`default_nettype wire

// File: rtl/unsigned_8x8_mul.sv
// ============================================================================
//  Module   : unsigned_8x8_mul
//  Purpose  : Registered unsigned 8x8 Dadda-tree multiplier with optional
//             truncation of the TRUNC least-significant partial-product
//             columns (no compensation; result never exceeds x*y).
//  Params   : BIT (must be 8), TRUNC (0..8)
//  Ports    : clk, rst_n (async, active-low), i_valid, x, y  (in)
//             o_valid, z                                     (out, registered)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module unsigned_8x8_mul
  import mul_pkg::*;
#(
  parameter int BIT   = 8,
  parameter int TRUNC = 0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_valid,
  input  opnd_t x,
  input  opnd_t y,
  output logic  o_valid,
  output prod_t z
);

  localparam int c_N    = mul_pkg::BIT;
  localparam int c_PW   = PW;
  localparam int c_MAXH = c_N;  // tallest column of the untouched array

  if (BIT != mul_pkg::BIT) begin : g_bad_bit
    $error("unsigned_8x8_mul: only BIT = 8 is supported");
  end
  if (TRUNC < 0 || TRUNC > 8) begin : g_bad_trunc
    $error("unsigned_8x8_mul: TRUNC must be within 0..8");
  end

  // --------------------------------------------------------------------------
  // Partial products with truncation mask. Dropped bits stay in the tree as
  // constant zeros so the tree shape is independent of TRUNC.
  // --------------------------------------------------------------------------
  logic w_pp [0:c_N-1][0:c_N-1];

  for (genvar i = 0; i < c_N; i++) begin : g_pp_row
    for (genvar j = 0; j < c_N; j++) begin : g_pp_col
      if (i + j < TRUNC) begin : g_drop
        assign w_pp[i][j] = 1'b0;
      end else begin : g_keep
        assign w_pp[i][j] = x[i] & y[j];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Dadda tree. w_tree[s][c][k] is bit k of column c entering stage s;
  // w_cy[s][c][k] are carries produced in column c during stage s.
  // Output column order: adder sums, pass-through bits, carries from c-1.
  // --------------------------------------------------------------------------
  logic w_tree [0:NSTAGE][0:c_PW-1][0:c_MAXH-1];
  logic w_cy   [0:NSTAGE-1][0:c_PW-1][0:c_MAXH-1];

  for (genvar c = 0; c < c_PW; c++) begin : g_col0
    localparam int H0  = dadda_cnt(0, c, KIND_H);
    localparam int ILO = (c >= c_N) ? c - c_N + 1 : 0;
    for (genvar k = 0; k < c_MAXH; k++) begin : g_bit
      if (k < H0) begin : g_pp
        assign w_tree[0][c][k] = w_pp[ILO+k][c-ILO-k];
      end else begin : g_nil
        assign w_tree[0][c][k] = 1'b0;
      end
    end
  end

  for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
    for (genvar c = 0; c < c_PW; c++) begin : g_col
      localparam int H  = dadda_cnt(s, c, KIND_H);
      localparam int NF = dadda_cnt(s, c, KIND_FA);
      localparam int NH = dadda_cnt(s, c, KIND_HA);
      localparam int NP = H - 3*NF - 2*NH;
      localparam int NC = (c == 0) ? 0 :
                          dadda_cnt(s, c-1, KIND_FA) + dadda_cnt(s, c-1, KIND_HA);
      localparam int HO = NF + NH + NP + NC;

      if (NP < 0 || HO > dadda_height(s) || HO != dadda_cnt(s+1, c, KIND_H) ||
          (c == c_PW-1 && NF + NH != 0)) begin : g_bad_shape
        $error("unsigned_8x8_mul: inconsistent Dadda tree shape");
      end

      for (genvar f = 0; f < NF; f++) begin : g_fa
        mul_fa u_fa (
          .a    (w_tree[s][c][3*f]),
          .b    (w_tree[s][c][3*f+1]),
          .cin  (w_tree[s][c][3*f+2]),
          .s    (w_tree[s+1][c][f]),
          .cout (w_cy[s][c][f])
        );
      end

      for (genvar g = 0; g < NH; g++) begin : g_ha
        assign w_tree[s+1][c][NF+g] = w_tree[s][c][3*NF+2*g] ^ w_tree[s][c][3*NF+2*g+1];
        assign w_cy[s][c][NF+g]     = w_tree[s][c][3*NF+2*g] & w_tree[s][c][3*NF+2*g+1];
      end

      for (genvar p = 0; p < NP; p++) begin : g_pass
        assign w_tree[s+1][c][NF+NH+p] = w_tree[s][c][3*NF+2*NH+p];
      end

      for (genvar q = 0; q < NC; q++) begin : g_cin
        assign w_tree[s+1][c][NF+NH+NP+q] = w_cy[s][c-1][q];
      end

      for (genvar k = HO; k < c_MAXH; k++) begin : g_nil
        assign w_tree[s+1][c][k] = 1'b0;
      end

      for (genvar k = NF + NH; k < c_MAXH; k++) begin : g_nocy
        assign w_cy[s][c][k] = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Final carry-propagate adder on the two remaining rows. The top carry is
  // always zero because the product fits in 16 bits.
  // --------------------------------------------------------------------------
  prod_t w_row_a;
  prod_t w_row_b;
  prod_t z_d;

  for (genvar c = 0; c < c_PW; c++) begin : g_rows
    assign w_row_a[c] = w_tree[NSTAGE][c][0];
    assign w_row_b[c] = w_tree[NSTAGE][c][1];
  end

  assign z_d = w_row_a + w_row_b;

  // --------------------------------------------------------------------------
  // Output register: operands are captured every cycle, i_valid only
  // qualifies o_valid.
  // --------------------------------------------------------------------------
  prod_t z_q;
  logic  valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      z_q     <= z_d;
      valid_q <= i_valid;
    end
  end

  assign z       = z_q;
  assign o_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_unsigned_8x8_mul.sv
// ============================================================================
//  Module   : tb_unsigned_8x8_mul
//  Purpose  : Self-checking bench for unsigned_8x8_mul: exact instance
//             (TRUNC=0) and truncating instance (TRUNC=4) share stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_unsigned_8x8_mul;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        ov0;
  logic [15:0] z0;
  logic        ov4;
  logic [15:0] z4;

  int n_checks = 0;
  int n_errors = 0;

  unsigned_8x8_mul #(.BIT(8), .TRUNC(0)) u_dut_exact (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .x       (x),
    .y       (y),
    .o_valid (ov0),
    .z       (z0)
  );

  unsigned_8x8_mul #(.BIT(8), .TRUNC(4)) u_dut_trunc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .x       (x),
    .y       (y),
    .o_valid (ov4),
    .z       (z4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Exact product minus the weight of every partial product in columns < t.
  function automatic int trunc_model(input int a, input int b, input int t);
    int p;
    p = a * b;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (i + j < t && a[i] && b[j]) p = p - (1 << (i + j));
    return p;
  endfunction

  // Present one pair, then sample just after the capturing edge.
  task automatic drive(input int a, input int b, input logic v);
    @(negedge clk);
    x       = 8'(a);
    y       = 8'(b);
    i_valid = v;
    @(posedge clk);
    #1;
  endtask

  int cx[5] = '{255,   0, 200, 128,   1};
  int cy[5] = '{255, 173,   3,   2, 255};
  int cz[5] = '{65025, 0, 600, 256, 255};

  int lx[4] = '{3, 9, 10, 2};
  int ly[4] = '{4, 9, 10, 7};
  int lz[4] = '{12, 81, 100, 14};
  logic lv[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  int abs_err_sum;
  int le_violations;
  int prod;

  initial begin
    rst_n       = 1'b1;
    i_valid     = 1'b0;
    x           = 8'd0;
    y           = 8'd0;
    abs_err_sum = 0;
    le_violations = 0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("reset_z_exact", 32'(z0), 0);
    check("reset_v_exact", 32'(ov0), 0);
    check("reset_z_trunc", 32'(z4), 0);
    @(posedge clk); #1;
    check("reset_hold_v", 32'(ov0), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Corners, exact instance
    for (int k = 0; k < 5; k++) begin
      drive(cx[k], cy[k], 1'b1);
      check($sformatf("corner_%0dx%0d", cx[k], cy[k]), 32'(z0), 32'(cz[k]));
      check("corner_valid", 32'(ov0), 1);
    end

    // Truncation corners (dropped weight 1+4+12+32 = 49 when all low bits set)
    drive(15, 15, 1'b1);
    check("trunc_15x15", 32'(z4), 176);
    drive(255, 255, 1'b1);
    check("trunc_255x255", 32'(z4), 64976);

    // Latency / valid qualification: z updates even when o_valid is 0
    for (int k = 0; k < 4; k++) begin
      drive(lx[k], ly[k], lv[k]);
      check($sformatf("lat_z_%0d", k), 32'(z0), 32'(lz[k]));
      check($sformatf("lat_v_%0d", k), 32'(ov0), 32'(lv[k]));
    end

    // Asynchronous reset between edges
    drive(250, 250, 1'b1);
    check("pre_rst_z", 32'(z0), 62500);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_z", 32'(z0), 0);
    check("async_rst_v", 32'(ov0), 0);
    check("async_rst_z_trunc", 32'(z4), 0);
    @(posedge clk); #1;
    check("rst_held_z", 32'(z0), 0);
    @(negedge clk);
    x       = 8'd7;
    y       = 8'd9;
    i_valid = 1'b1;
    rst_n   = 1'b1;
    @(posedge clk); #1;
    check("post_rst_z", 32'(z0), 63);
    check("post_rst_v", 32'(ov0), 1);

    // Exhaustive sweep, y fastest, back-to-back valid pairs
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        drive(a, b, 1'b1);
        prod = a * b;
        check("sweep_exact", 32'(z0), 32'(prod));
        check("sweep_trunc", 32'(z4), 32'(trunc_model(a, b, 4)));
        abs_err_sum = abs_err_sum + ((int'(z0) > prod) ? int'(z0) - prod : prod - int'(z0));
        if (int'(z4) > prod) le_violations++;
      end
    end
    check("sweep_abs_err_sum", 32'(abs_err_sum), 0);
    check("trunc_le_violations", 32'(le_violations), 0);
    check("sweep_last_valid", 32'(ov0), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
